frame_sequencer: RTL and testbench

Per-frame scheduler that owns the single VGA write port and shares it among N drawing clients (platform, ball, bricks). Each frame tick it issues one movement `enable` pulse to all clients, then starts each client in fixed order with a one-cycle `draw` pulse. While a client runs, its pixel stream is forwarded to the VGA adapter until the client reports done or a timeout expires. It sits between the object blocks and the VGA adapter.

---
 rtl/bb_pkg.sv | 28 ++
 rtl/frame_sequencer_tick_divider.sv | 30 +++
 rtl/frame_sequencer.sv | 154 +++++++++++++++
 tb/tb_frame_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bb_pkg.sv
// Shared types and helpers for the frame sequencer and its drawing clients.
// Client buses are packed back to back; get_field pulls out one client's slot.
package bb_pkg;

    localparam int COORD_W     = 10;
    localparam int COLOUR_W    = 3;
    // Widest packed client bus the field helper accepts (32 clients of COORD_W bits).
    localparam int FIELD_BUS_W = 320;

    typedef enum logic [2:0] {
        ST_WAIT   = 3'd0,
        ST_ENABLE = 3'd1,
        ST_START  = 3'd2,
        ST_RUN    = 3'd3,
        ST_NEXT   = 3'd4
    } seq_state_t;

    function automatic logic [COORD_W-1:0] get_field(
        input logic [FIELD_BUS_W-1:0] bus,
        input int unsigned            idx,
        input int unsigned            width
    );
        logic [FIELD_BUS_W-1:0] mask;
        mask = ({{(FIELD_BUS_W-1){1'b0}}, 1'b1} << width) - {{(FIELD_BUS_W-1){1'b0}}, 1'b1};
        return COORD_W'((bus >> (idx * width)) & mask);
    endfunction

endpackage

// File: rtl/frame_sequencer_tick_divider.sv
// Free-running frame divider: counts 0..FRAME_DIV-1 and flags the last count.
// Runs independently of the sequencer state and of pause.
module tick_divider #(
    parameter int FRAME_DIV = 833334
) (
    input  logic i_clk,
    input  logic i_resetn,
    output logic o_tick
);

    localparam int              CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_DIV - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_last;

    assign w_last = (r_count == LAST);
    assign o_tick = w_last;

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_count <= '0;
        end else if (w_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame scheduler owning the single VGA write port: one enable pulse per frame,
// then each client in index order gets a draw pulse and the port until done or timeout.
module frame_sequencer
    import bb_pkg::*;
#(
    parameter int N_CLIENTS = 3,
    parameter int FRAME_DIV = 833334,
    parameter int TIMEOUT   = 1023
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          pause,
    input  logic [N_CLIENTS-1:0]          client_done,
    input  logic [N_CLIENTS-1:0]          client_wren,
    input  logic [COORD_W*N_CLIENTS-1:0]  client_x,
    input  logic [COORD_W*N_CLIENTS-1:0]  client_y,
    input  logic [COLOUR_W*N_CLIENTS-1:0] client_colour,
    output logic                          client_enable,
    output logic [N_CLIENTS-1:0]          client_draw,
    output logic [COORD_W-1:0]            vga_x,
    output logic [COORD_W-1:0]            vga_y,
    output logic [COLOUR_W-1:0]           vga_colour,
    output logic                          vga_plot,
    output logic                          busy,
    output logic                          overrun,
    output logic                          timeout_err,
    output logic [15:0]                   frame_count,
    output seq_state_t                    dbg_state
);

    localparam int                    CUR_W    = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam int                    TCNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CUR_W-1:0]      LAST_CUR = CUR_W'(N_CLIENTS - 1);
    localparam logic [TCNT_W-1:0]     TO_LAST  = TCNT_W'(TIMEOUT - 1);
    localparam logic [N_CLIENTS-1:0]  DRAW_ONE = N_CLIENTS'(1);

    seq_state_t          r_state;
    seq_state_t          w_next_state;
    logic [CUR_W-1:0]    r_cur;
    logic [CUR_W-1:0]    w_next_cur;
    logic [TCNT_W-1:0]   r_tcnt;
    logic [TCNT_W-1:0]   w_next_tcnt;
    logic [15:0]         r_frame_count;
    logic                r_overrun;
    logic                r_timeout_err;
    logic                w_tick;
    logic                w_set_timeout;
    logic                w_frame_done;
    logic                w_forward;

    tick_divider #(
        .FRAME_DIV (FRAME_DIV)
    ) u_tick_divider (
        .i_clk    (clk),
        .i_resetn (resetn),
        .o_tick   (w_tick)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state       <= ST_WAIT;
            r_cur         <= '0;
            r_tcnt        <= '0;
            r_frame_count <= '0;
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cur   <= w_next_cur;
            r_tcnt  <= w_next_tcnt;
            // A tick outside WAIT is only recorded; the frame in flight is untouched.
            if (w_tick && (r_state != ST_WAIT)) begin
                r_overrun <= 1'b1;
            end
            if (w_set_timeout) begin
                r_timeout_err <= 1'b1;
            end
            if (w_frame_done) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_next_cur    = r_cur;
        w_next_tcnt   = r_tcnt;
        w_set_timeout = 1'b0;
        w_frame_done  = 1'b0;
        client_enable = 1'b0;
        client_draw   = '0;
        case (r_state)
            ST_WAIT: begin
                if (w_tick && !pause) begin
                    w_next_state = ST_ENABLE;
                end
            end
            ST_ENABLE: begin
                client_enable = 1'b1;
                w_next_cur    = '0;
                w_next_state  = ST_START;
            end
            ST_START: begin
                client_draw  = DRAW_ONE << r_cur;
                w_next_tcnt  = '0;
                w_next_state = ST_RUN;
            end
            ST_RUN: begin
                w_next_tcnt = r_tcnt + TCNT_W'(1);
                // done has priority over a timeout landing in the same cycle
                if (client_done[r_cur]) begin
                    w_next_state = ST_NEXT;
                end else if (r_tcnt == TO_LAST) begin
                    w_set_timeout = 1'b1;
                    w_next_state  = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (r_cur == LAST_CUR) begin
                    w_frame_done = 1'b1;
                    w_next_state = ST_WAIT;
                end else begin
                    w_next_cur   = r_cur + CUR_W'(1);
                    w_next_state = ST_START;
                end
            end
            default: begin
                w_next_state = ST_WAIT;
            end
        endcase
    end

    assign w_forward = (r_state == ST_START) || (r_state == ST_RUN);

    always_comb begin
        vga_plot   = 1'b0;
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        if (w_forward) begin
            vga_plot   = client_wren[r_cur];
            vga_x      = get_field(FIELD_BUS_W'(client_x), 32'(r_cur), COORD_W);
            vga_y      = get_field(FIELD_BUS_W'(client_y), 32'(r_cur), COORD_W);
            vga_colour = COLOUR_W'(get_field(FIELD_BUS_W'(client_colour), 32'(r_cur), COLOUR_W));
        end
    end

    assign busy        = (r_state != ST_WAIT);
    assign overrun     = r_overrun;
    assign timeout_err = r_timeout_err;
    assign frame_count = r_frame_count;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: a schedule-level model of each frame drives the clients
// and predicts every output cycle by cycle; a second instance covers overrun.
module tb_frame_sequencer;
    import bb_pkg::*;

    localparam int N    = 3;
    localparam int FDIV = 64;
    localparam int T    = 16;
    localparam int TB_T = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // instance A: model-checked
    logic        resetn, pause;
    logic [2:0]  done_a, wren_a;
    logic [29:0] x_a, y_a;
    logic [8:0]  col_a;
    logic        en_a, plot_a, busy_a, ovr_a, to_a;
    logic [2:0]  draw_a;
    logic [9:0]  vx_a, vy_a;
    logic [2:0]  vc_a;
    logic [15:0] fc_a;
    seq_state_t  st_a;

    // instance B: long stall against a wide timeout
    logic        resetn_b, pause_b;
    logic [2:0]  done_b, wren_b;
    logic [29:0] x_b, y_b;
    logic [8:0]  col_b;
    logic        en_b, plot_b, busy_b, ovr_b, to_b;
    logic [2:0]  draw_b;
    logic [9:0]  vx_b, vy_b;
    logic [2:0]  vc_b;
    logic [15:0] fc_b;
    seq_state_t  st_b;

    frame_sequencer #(.N_CLIENTS(N), .FRAME_DIV(FDIV), .TIMEOUT(T)) dut_a (
        .clk(clk), .resetn(resetn), .pause(pause),
        .client_done(done_a), .client_wren(wren_a),
        .client_x(x_a), .client_y(y_a), .client_colour(col_a),
        .client_enable(en_a), .client_draw(draw_a),
        .vga_x(vx_a), .vga_y(vy_a), .vga_colour(vc_a), .vga_plot(plot_a),
        .busy(busy_a), .overrun(ovr_a), .timeout_err(to_a),
        .frame_count(fc_a), .dbg_state(st_a)
    );

    frame_sequencer #(.N_CLIENTS(N), .FRAME_DIV(FDIV), .TIMEOUT(TB_T)) dut_b (
        .clk(clk), .resetn(resetn_b), .pause(pause_b),
        .client_done(done_b), .client_wren(wren_b),
        .client_x(x_b), .client_y(y_b), .client_colour(col_b),
        .client_enable(en_b), .client_draw(draw_b),
        .vga_x(vx_b), .vga_y(vy_b), .vga_colour(vc_b), .vga_plot(plot_b),
        .busy(busy_b), .overrun(ovr_b), .timeout_err(to_b),
        .frame_count(fc_b), .dbg_state(st_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // Frame plan: m_e enable cycle, m_s[i] start cycles, m_r[i] RUN lengths, m_w first WAIT cycle.
    bit          m_ok = 1'b0;
    bit          m_plan = 1'b0;
    int          m_c = 0;
    int          m_e, m_w, m_prev;
    int          m_s[N];
    int          m_r[N];
    int          m_k[N];
    bit          m_w4;
    bit          m_tk, m_bz;
    logic [15:0] m_fc;
    bit          m_ovr, m_to;

    bit f_valid = 1'b0;
    bit f_w4 = 1'b0;
    int f_k[N];
    int specials[4] = '{15, 16, 17, 30};

    function automatic int rand_k();
        if ($urandom_range(0, 9) < 7) return int'($urandom_range(0, 6));
        return specials[$urandom_range(0, 3)];
    endfunction

    // k = cycles after START until done rises; done is first looked at in the first RUN cycle.
    task automatic plan_frame();
        m_plan = 1'b1;
        m_e    = m_c;
        for (int i = 0; i < N; i++) m_k[i] = f_valid ? f_k[i] : rand_k();
        m_w4    = f_valid && f_w4;
        f_valid = 1'b0;
        m_s[0]  = m_e + 1;
        for (int i = 0; i < N; i++) begin
            m_r[i] = (m_k[i] == 0) ? 1 : ((m_k[i] > T) ? T : m_k[i]);
            if (i < N - 1) m_s[i+1] = m_s[i] + m_r[i] + 2;
        end
        m_w = m_s[N-1] + m_r[N-1] + 2;
    endtask

    always @(posedge clk) begin
        if (!resetn) begin
            m_ok = 1'b1; m_c = 0; m_plan = 1'b0;
            m_fc = '0; m_ovr = 1'b0; m_to = 1'b0;
        end else if (m_ok) begin
            m_prev = m_c;
            m_tk   = (m_prev % FDIV) == FDIV - 1;
            m_bz   = m_plan && (m_prev >= m_e) && (m_prev < m_w);
            m_c    = m_c + 1;
            if (m_plan && m_c == m_w) m_fc = m_fc + 16'd1;
            for (int i = 0; i < N; i++)
                if (m_plan && m_k[i] > T && m_c == m_s[i] + T + 1) m_to = 1'b1;
            if (m_tk) begin
                if (m_bz) m_ovr = 1'b1;
                else if (!pause) plan_frame();
            end
        end
    end

    always @(posedge clk) begin
        #1;
        x_a    = 30'($urandom);
        y_a    = 30'($urandom);
        col_a  = 9'($urandom);
        wren_a = 3'($urandom);
        for (int i = 0; i < N; i++) begin
            if (m_plan && m_c >= m_s[i] && m_c < m_w) done_a[i] = (m_c >= m_s[i] + m_k[i]);
            else done_a[i] = 1'($urandom_range(0, 1));
            if (m_plan && m_w4 && m_c >= m_s[i] && m_c <= m_s[i] + m_r[i])
                wren_a[i] = (m_c < m_s[i] + 4);
        end
    end

    logic [2:0] e_draw;
    logic [9:0] e_x, e_y;
    logic [2:0] e_col;
    logic       e_plot, e_busy, e_en;
    int         e_act;
    int         plot_cnt = 0;
    int         en_cnt = 0;

    always @(negedge clk) begin
        if (m_ok) begin
            e_busy = m_plan && m_c >= m_e && m_c < m_w;
            e_en   = m_plan && m_c == m_e;
            e_draw = '0;
            e_act  = -1;
            for (int i = 0; i < N; i++) begin
                if (m_plan && m_c == m_s[i]) e_draw[i] = 1'b1;
                if (m_plan && m_c >= m_s[i] && m_c <= m_s[i] + m_r[i]) e_act = i;
            end
            e_plot = 1'b0; e_x = '0; e_y = '0; e_col = '0;
            if (e_act >= 0) begin
                e_plot = wren_a[e_act];
                e_x    = x_a[e_act*10 +: 10];
                e_y    = y_a[e_act*10 +: 10];
                e_col  = col_a[e_act*3 +: 3];
            end
            chk("enable", en_a, e_en);
            chk("draw", draw_a, e_draw);
            chk("plot", plot_a, e_plot);
            chk("vga_x", vx_a, e_x);
            chk("vga_y", vy_a, e_y);
            chk("vga_colour", vc_a, e_col);
            chk("busy", busy_a, e_busy);
            chk("overrun", ovr_a, m_ovr);
            chk("timeout_err", to_a, m_to);
            chk("frame_count", fc_a, m_fc);
            if (plot_a) plot_cnt++;
            if (en_a) en_cnt++;
        end
    end

    task automatic go_to(input int target);
        int n;
        n = 0;
        do begin
            @(posedge clk); #2; n++;
        end while (m_c != target && n < 3000);
        if (m_c != target) chk("wait_cycle_a", m_c, target);
    endtask

    // Instance B bookkeeping
    int cb = 0;
    int en_b_cnt = 0;
    bit b_done = 1'b0;

    always @(posedge clk) begin
        if (!resetn_b) cb = 0;
        else cb++;
    end

    always @(posedge clk) begin
        #1;
        done_b = (cb >= 141) ? 3'b111 : 3'b011;
        wren_b = 3'($urandom);
        x_b    = 30'($urandom);
        y_b    = 30'($urandom);
        col_b  = 9'($urandom);
    end

    always @(negedge clk) if (resetn_b && en_b && cb < 192) en_b_cnt++;

    task automatic go_to_b(input int target);
        int n;
        n = 0;
        do begin
            @(posedge clk); #2; n++;
        end while (cb != target && n < 3000);
        if (cb != target) chk("wait_cycle_b", cb, target);
    endtask

    initial begin
        wait (resetn_b === 1'b1);
        go_to_b(71);
        chk("b_draw2", draw_b, 3'b100);
        go_to_b(127);
        chk("b_overrun_before", ovr_b, 1'b0);
        chk("b_busy_at_tick", busy_b, 1'b1);
        go_to_b(128);
        chk("b_overrun_set", ovr_b, 1'b1);
        go_to_b(142);
        chk("b_busy_next", busy_b, 1'b1);
        chk("b_fc_before", fc_b, 16'd0);
        go_to_b(143);
        chk("b_busy_wait", busy_b, 1'b0);
        chk("b_fc_after", fc_b, 16'd1);
        chk("b_timeout_clear", to_b, 1'b0);
        chk("b_state_wait", st_b, ST_WAIT);
        go_to_b(191);
        chk("b_enable_count", en_b_cnt, 1);
        go_to_b(192);
        chk("b_next_enable", en_b, 1'b1);
        chk("b_overrun_sticky", ovr_b, 1'b1);
        b_done = 1'b1;
    end

    initial begin
        int n;
        resetn = 1'b0; resetn_b = 1'b0; pause = 1'b0; pause_b = 1'b0;
        done_a = '0; wren_a = '0; x_a = '0; y_a = '0; col_a = '0;
        done_b = '0; wren_b = '0; x_b = '0; y_b = '0; col_b = '0;
        f_k = '{4, 4, 4}; f_w4 = 1'b1; f_valid = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        resetn = 1'b1; resetn_b = 1'b1;

        chk("rst_busy", busy_a, 1'b0);
        chk("rst_plot", plot_a, 1'b0);
        chk("rst_vga_x", vx_a, 10'd0);
        chk("rst_enable", en_a, 1'b0);
        chk("rst_draw", draw_a, 3'b000);
        chk("rst_fc", fc_a, 16'd0);
        chk("rst_flags", {ovr_a, to_a}, 2'b00);
        chk("rst_state", st_a, ST_WAIT);

        // four pixels per client, done after four RUN cycles
        go_to(63);
        plot_cnt = 0;
        chk("lit_no_enable_63", en_a, 1'b0);
        go_to(64);
        chk("lit_enable_64", en_a, 1'b1);
        go_to(65);
        chk("lit_draw0_65", draw_a, 3'b001);
        go_to(71);
        chk("lit_draw1_71", draw_a, 3'b010);
        go_to(77);
        chk("lit_draw2_77", draw_a, 3'b100);
        go_to(82);
        chk("lit_fc_82", fc_a, 16'd0);
        go_to(83);
        chk("lit_fc_83", fc_a, 16'd1);
        chk("lit_busy_83", busy_a, 1'b0);
        chk("lit_plot_count", plot_cnt, 12);

        // client 1 never finishes
        f_k = '{2, 99, 1}; f_w4 = 1'b0; f_valid = 1'b1;
        go_to(149);
        chk("lit_to_149", to_a, 1'b0);
        go_to(150);
        chk("lit_to_150", to_a, 1'b1);
        go_to(151);
        chk("lit_draw2_151", draw_a, 3'b100);
        go_to(153);
        chk("lit_fc_153", fc_a, 16'd1);
        go_to(154);
        chk("lit_fc_154", fc_a, 16'd2);

        // paused across the tick at 191
        go_to(180);
        pause = 1'b1;
        en_cnt = 0;
        go_to(230);
        chk("lit_pause_enables", en_cnt, 0);
        chk("lit_pause_busy", busy_a, 1'b0);
        chk("lit_pause_overrun", ovr_a, 1'b0);
        pause = 1'b0;

        for (int f = 0; f < 1600; f++) begin
            @(posedge clk); #2;
            if (f % 16 == 0) pause = ($urandom_range(0, 5) == 0);
        end
        pause = 1'b0;

        // reset in the first RUN cycle of client 1
        f_k = '{1, 5, 1}; f_w4 = 1'b0; f_valid = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #2; n++;
        end while (!(!f_valid && m_plan && m_c == m_s[1] + 1) && n < 300);
        if (n >= 300) chk("wait_mid_run", n, 0);
        chk("pre_reset_busy", busy_a, 1'b1);
        resetn = 1'b0;
        @(posedge clk); #2;
        chk("mid_rst_plot", plot_a, 1'b0);
        chk("mid_rst_fc", fc_a, 16'd0);
        chk("mid_rst_busy", busy_a, 1'b0);
        chk("mid_rst_draw", draw_a, 3'b000);
        chk("mid_rst_state", st_a, ST_WAIT);
        resetn = 1'b1;
        go_to(64);
        chk("restart_enable", en_a, 1'b1);
        go_to(65);
        chk("restart_draw0", draw_a, 3'b001);

        n = 0;
        while (!b_done && n < 1000) begin
            @(posedge clk); n++;
        end
        if (!b_done) chk("b_scenario_done", b_done, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
